// File: rtl/pushbutton_pio_debounced.sv
// Debounced pushbutton parallel input port with an Avalon-MM slave interface.
// Each input bit is synchronized, debounced, and edge-captured; captured edges
// can be masked into a level interrupt.
//
// Ports:
//   clk, reset_n     clock and asynchronous active-low reset
//   address          word address (0 stable, 1 zero, 2 irqmask, 3 edgecapture)
//   chipselect,write write strobe qualifiers
//   writedata        write data; irqmask load or edgecapture write-1-to-clear
//   readdata         registered read data, latency 1, loaded every clock
//   in_port          asynchronous active-low pushbutton inputs
//   irq              OR of (edgecapture & irqmask), from registers only
module pushbutton_pio_debounced #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_MODE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edgecap_nxt;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] irqmask;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic             wr_mask_c;
  logic             wr_clr_c;
  logic [31:0]      rd_nxt;
  logic             unused_wdata;

  // Upper write data bits beyond WIDTH are intentionally ignored.
  assign unused_wdata = ^writedata;

  // Two-flop synchronizer; idles high like an unpressed button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: accept a new level once it has differed for
  // DEBOUNCE_CYCLES consecutive clocks; any return to equality restarts.
  always_comb begin
    stable_nxt = stable;
    edge_set   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_nxt[i] = '0;
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        stable_nxt[i] = sync2[i];
        cnt_nxt[i]    = '0;
        if (EDGE_MODE == 0) begin
          edge_set[i] = sync2[i];
        end else if (EDGE_MODE == 1) begin
          edge_set[i] = ~sync2[i];
        end else begin
          edge_set[i] = 1'b1;
        end
      end else begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  // Register decode; a new edge wins over a same-cycle clear.
  always_comb begin
    wr_mask_c   = chipselect && write && (address == 2'd2);
    wr_clr_c    = chipselect && write && (address == 2'd3);
    edge_clr    = wr_clr_c ? writedata[WIDTH-1:0] : '0;
    edgecap_nxt = (edgecap & ~edge_clr) | edge_set;
  end

  // Read mux, sampled every clock from the current address.
  always_comb begin
    rd_nxt = '0;
    case (address)
      2'd0:    rd_nxt = 32'(stable);
      2'd1:    rd_nxt = '0;
      2'd2:    rd_nxt = 32'(irqmask);
      default: rd_nxt = 32'(edgecap);
    endcase
  end

  // Debounce state, register file, and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable   <= '1;
      edgecap  <= '0;
      irqmask  <= '0;
      readdata <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable   <= stable_nxt;
      edgecap  <= edgecap_nxt;
      readdata <= rd_nxt;
      if (wr_mask_c) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Interrupt is a pure function of registered state.
  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_pushbutton_pio_debounced.sv
// Scoreboard bench: expectations are queued with the cycle they become due
// and compared against the DUT on the falling edge of that cycle.
module tb_pushbutton_pio_debounced;

  localparam int unsigned W  = 4;
  localparam int unsigned DB = 4;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [31:0]   readdata2;
  logic [W-1:0]  in_port;
  logic [W-1:0]  in_port2;
  logic          irq;
  logic          irq2;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
    int          due;
  } item_t;

  item_t sb[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  pushbutton_pio_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  pushbutton_pio_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(readdata2),
    .in_port(in_port2), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Queue an expectation for the value visible after the next rising edge.
  task automatic expect_at(input int sel, input logic [31:0] exp, input string tag);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    it.due = cyc + 1;
    sb.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input int sel, input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    expect_at(sel, exp, tag);
    tick(1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
  endtask

  // Monitor: pop every expectation that has come due and compare.
  always @(negedge clk) begin
    item_t       it;
    logic [31:0] got;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      it = sb.pop_front();
      case (it.sel)
        0:       got = readdata;
        1:       got = {31'b0, irq};
        2:       got = readdata2;
        default: got = {31'b0, irq2};
      endcase
      check_val(it.tag, got, it.exp);
    end
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    in_port    = '1;
    in_port2   = '1;

    // Reset state and first read
    tick(1);
    expect_at(0, 32'h0, "rst_readdata");
    expect_at(1, 32'h0, "rst_irq");
    tick(2);
    reset_n = 1'b1;
    expect_at(1, 32'h0, "idle_irq");
    rd(0, 2'd0, 32'h0000_000F, "idle_stable");

    // Three-cycle glitch on bit 0 is rejected
    in_port[0] = 1'b0;
    tick(3);
    in_port[0] = 1'b1;
    tick(8);
    rd(0, 2'd0, 32'hF, "glitch_stable");
    expect_at(1, 32'h0, "glitch_irq");
    rd(0, 2'd3, 32'h0, "glitch_edge");

    // Held press on bit 1: exact 2+DB latency then readdata one later
    address    = 2'd0;
    in_port[1] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      expect_at(0, (k < 7) ? 32'hF : 32'hD, $sformatf("press_lat%0d", k));
      tick(1);
    end
    expect_at(1, 32'h0, "unmasked_irq");
    rd(0, 2'd3, 32'h2, "press_edge");
    expect_at(1, 32'h1, "mask_irq");
    wr(2'd2, 32'h2);
    rd(0, 2'd2, 32'h2, "mask_rd");

    // Write-1-to-clear
    expect_at(1, 32'h0, "clr_irq");
    wr(2'd3, 32'h2);
    rd(0, 2'd3, 32'h0, "clr_edge");

    // Writes to addresses 0 and 1 do nothing
    wr(2'd0, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(0, 2'd0, 32'hD, "wr0_noeffect");
    rd(0, 2'd1, 32'h0, "addr1_zero");

    // Release: rising edge not captured in falling mode
    in_port[1] = 1'b1;
    tick(8);
    rd(0, 2'd0, 32'hF, "release_stable");
    rd(0, 2'd3, 32'h0, "no_rise_capture");

    // New falling edge lands on the same clock as a clear: set wins
    in_port[1] = 1'b0;
    tick(5);
    expect_at(1, 32'h1, "setclr_irq");
    wr(2'd3, 32'h2);
    rd(0, 2'd3, 32'h2, "setclr_edge");

    // Two more channels pressed together
    in_port[0] = 1'b0;
    in_port[3] = 1'b0;
    tick(7);
    rd(0, 2'd0, 32'h4, "multi_stable");
    rd(0, 2'd3, 32'hB, "multi_edge");
    expect_at(1, 32'h0, "multi_clr_irq");
    wr(2'd3, 32'hF);
    rd(0, 2'd3, 32'h0, "multi_clr_edge");

    // Reset mid-debounce discards the partial count
    in_port = '1;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(8);
    in_port[2] = 1'b0;
    tick(5);
    reset_n = 1'b0;
    expect_at(0, 32'h0, "midrst_readdata");
    expect_at(1, 32'h0, "midrst_irq");
    tick(2);
    reset_n = 1'b1;
    address = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      expect_at(0, (k < 7) ? 32'hF : 32'hB, $sformatf("postrst_lat%0d", k));
      tick(1);
    end

    // Any-edge instance: capture on press and on release
    in_port2[3] = 1'b0;
    tick(7);
    rd(2, 2'd3, 32'h8, "any_fall");
    expect_at(3, 32'h0, "any_irq_unmasked");
    wr(2'd3, 32'h8);
    rd(2, 2'd3, 32'h0, "any_clr");
    in_port2[3] = 1'b1;
    tick(7);
    rd(2, 2'd3, 32'h8, "any_rise");
    rd(2, 2'd0, 32'hF, "any_stable");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) check_val("sb_drain", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pushbutton_pio_debounced.md
PUSHBUTTON_PIO_DEBOUNCED -- requirements
Module: pushbutton_pio_debounced

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, number of input bits (legal 1..32).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required to accept a level change (legal >= 1).
REQ-003 SHALL provide parameter EDGE_MODE, default 1, captured edge: 0 rising, 1 falling, 2 any.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select, qualifies write.
REQ-009 write  input  1  active-high write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  registered read data, read latency 1.
REQ-012 in_port  input  WIDTH  asynchronous pushbutton inputs, active-low (idle 1).
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 Each in_port bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Per bit, a counter of width clog2(DEBOUNCE_CYCLES+1) SHALL clear whenever synchronized value equals stable value, and increment while they differ.
REQ-016 Stable bit SHALL take the synchronized value, and its counter clear, on the edge where they have differed for DEBOUNCE_CYCLES consecutive cycles; any return to equality earlier restarts the count.
REQ-017 Latency in_port change to stable update SHALL be 2 + DEBOUNCE_CYCLES clocks for a clean change.
REQ-018 edgecapture[i] SHALL set on the same edge stable[i] changes, if the transition matches EDGE_MODE (0: 0->1, 1: 1->0, 2: either).
REQ-019 Register map (read): addr 0 = stable; addr 1 = 0; addr 2 = irqmask; addr 3 = edgecapture; bits 31..WIDTH read 0.
REQ-020 readdata SHALL be loaded every clock from the current address, independent of read strobe.
REQ-021 Write with chipselect=1, write=1, address=2 SHALL load irqmask <= writedata[WIDTH-1:0].
REQ-022 Write to address 3 SHALL clear every edgecapture bit whose writedata bit is 1; others unchanged.
REQ-023 Simultaneous set (REQ-018) and clear (REQ-022) on the same bit SHALL leave the bit set.
REQ-024 Writes to addresses 0 and 1 SHALL have no effect.
REQ-025 irq SHALL equal OR-reduction of (edgecapture & irqmask), derived only from registers, no input-to-irq combinational path.
REQ-026 Channels SHALL be fully independent; simultaneous events on several bits each obey REQ-015..REQ-023.

Reset
REQ-027 On reset_n=0: readdata=0, irqmask=0, edgecapture=0, counters=0, synchronizer and stable flops all ones, irq=0.
REQ-028 Reset assertion mid-debounce SHALL discard partial counts; after release a held-low input SHALL need the full 2 + DEBOUNCE_CYCLES to register.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_MODE=1 unless noted)
REQ-029 Reset, in_port=4'hF, read addr 0 -> readdata 0 during reset, 32'h0000000F one cycle after address applied; irq 0.
REQ-030 in_port[0] low for 3 clocks then high -> addr 0 stays 0xF, edgecapture 0x0, irq 0.
REQ-031 in_port[1] held low -> addr 0 reads 0xD after 6 clocks, edgecapture 0x2, irq 0; write 0x2 to addr 2 -> irq 1 next cycle.
REQ-032 Write 0x2 to addr 3 -> edgecapture 0x0, irq 0 next cycle; repeat with clear on the same edge as a new falling edge on bit 1 -> edgecapture stays 0x2.
REQ-033 EDGE_MODE=2, press then release bit 3, clearing between -> edgecapture 0x8 after each transition.
REQ-034 Assert reset_n after 3 of 4 debounce cycles on bit 2 held low -> after release, addr 0 reads 0xB only after a further 6 clocks.
